// File: rtl/immediate_gen.sv
// RV32I immediate generator: combinational extract/sign-extend by format select,
// plus a registered copy with a valid flag for pipelined or debug consumers.
module immediate_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [2:0]  ImmSel,
  input  logic        in_valid,
  output logic [31:0] imm_out,
  output logic        imm_illegal,
  output logic [31:0] imm_q,
  output logic        imm_q_valid
);

  localparam logic [2:0] SelI     = 3'b000;
  localparam logic [2:0] SelS     = 3'b001;
  localparam logic [2:0] SelB     = 3'b010;
  localparam logic [2:0] SelU     = 3'b011;
  localparam logic [2:0] SelJ     = 3'b100;
  localparam logic [2:0] SelShamt = 3'b101;
  localparam logic [2:0] SelZimm  = 3'b110;

  logic sign;
  assign sign = instr[31];

  always_comb begin
    imm_out     = 32'h0;
    imm_illegal = 1'b0;
    unique case (ImmSel)
      SelI:     imm_out = {{20{sign}}, instr[31:20]};
      SelS:     imm_out = {{20{sign}}, instr[31:25], instr[11:7]};
      SelB:     imm_out = {{19{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      SelU:     imm_out = {instr[31:12], 12'h000};
      SelJ:     imm_out = {{11{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      SelShamt: imm_out = {27'h0, instr[24:20]};
      SelZimm:  imm_out = {27'h0, instr[19:15]};
      default:  imm_illegal = 1'b1;
    endcase
  end

  // imm_q holds across invalid cycles; only the valid flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q       <= 32'h0;
      imm_q_valid <= 1'b0;
    end else begin
      imm_q_valid <= in_valid;
      if (in_valid) begin
        imm_q <= imm_out;
      end
    end
  end

endmodule

// File: tb/tb_immediate_gen.sv
// Self-checking bench for immediate_gen: directed test-plan vectors, randomized
// comparisons against an arithmetic reference model, and registered-path scenarios.
module tb_immediate_gen;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [2:0]  ImmSel;
  logic        in_valid;
  logic [31:0] imm_out;
  logic        imm_illegal;
  logic [31:0] imm_q;
  logic        imm_q_valid;

  int n_checks;
  int n_errors;

  immediate_gen dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .ImmSel     (ImmSel),
    .in_valid   (in_valid),
    .imm_out    (imm_out),
    .imm_illegal(imm_illegal),
    .imm_q      (imm_q),
    .imm_q_valid(imm_q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Immediate as a signed integer built from weighted fields, then truncated to 32 bits.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
    longint v;
    longint s;
    logic [63:0] w;
    s = longint'(ins[31]);
    case (sel)
      3'd0: v = longint'(ins[30:20]) - s * 2048;
      3'd1: v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - s * 2048;
      3'd2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                + longint'(ins[11:8]) * 2 - s * 4096;
      3'd3: v = longint'(ins[31:12]) * 4096;
      3'd4: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                + longint'(ins[30:21]) * 2 - s * 1048576;
      3'd5: v = longint'(ins[24:20]);
      3'd6: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    w = v;
    return w[31:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; instr = 32'hFFB10093; ImmSel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (imm_q !== 32'h0) begin
      n_errors++; $display("FAIL reset_imm_q: got %h want %h", imm_q, 32'h0);
    end
    n_checks++;
    if (imm_q_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b want 0", imm_q_valid);
    end
    // Combinational path ignores reset.
    n_checks++;
    if (imm_out !== 32'hFFFFFFFB) begin
      n_errors++; $display("FAIL reset_comb: got %h want %h", imm_out, 32'hFFFFFFFB);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] vi [9] = '{32'hFFB10093, 32'hFC012023, 32'h00410063, 32'hABCD00B7,
                            32'hFFC0006F, 32'hFC9FF0EF, 32'h01F01013, 32'h000FD073,
                            32'h00000000};
    logic [2:0]  vs [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] ve [9] = '{32'hFFFFFFFB, 32'hFFFFFFC0, 32'h00000000, 32'hABCD0000,
                            32'hFFF007FC, 32'hFFFFFFC8, 32'h0000001F, 32'h0000001F,
                            32'h00000000};
    for (int i = 0; i < 9; i++) begin
      instr = vi[i]; ImmSel = vs[i];
      #1;
      n_checks++;
      if (imm_out !== ve[i]) begin
        n_errors++;
        $display("FAIL directed_%0d sel=%0d instr=%h: got %h want %h",
                 i, vs[i], vi[i], imm_out, ve[i]);
      end
      n_checks++;
      if (imm_illegal !== (vs[i] == 3'd7)) begin
        n_errors++;
        $display("FAIL directed_illegal_%0d: got %b want %b", i, imm_illegal, vs[i] == 3'd7);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q;
    logic        exp_v;
    exp_q = imm_q;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      instr    = $urandom;
      ImmSel   = 3'($urandom_range(0, 7));
      in_valid = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (imm_out !== ref_imm(instr, ImmSel) || imm_illegal !== (ImmSel == 3'd7)) begin
        n_errors++;
        $display("FAIL rand_comb sel=%0d instr=%h: got %h/%b want %h/%b", ImmSel, instr,
                 imm_out, imm_illegal, ref_imm(instr, ImmSel), ImmSel == 3'd7);
      end
      if (in_valid) exp_q = ref_imm(instr, ImmSel);
      exp_v = in_valid;
      @(posedge clk);
      #1;
      n_checks++;
      if (imm_q !== exp_q || imm_q_valid !== exp_v) begin
        n_errors++;
        $display("FAIL rand_reg: got %h/%b want %h/%b", imm_q, imm_q_valid, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vi [3] = '{32'hFFB10093, 32'hABCD00B7, 32'hFFC0006F};
    logic [2:0]  vs [3] = '{3'd0, 3'd3, 3'd4};
    logic [31:0] last;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      instr = vi[i]; ImmSel = vs[i]; in_valid = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (imm_q !== ref_imm(vi[i], vs[i]) || imm_q_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_%0d: got %h/%b want %h/1", i, imm_q, imm_q_valid,
                 ref_imm(vi[i], vs[i]));
      end
      @(negedge clk);
    end
    last = ref_imm(vi[2], vs[2]);
    // Hold: new data on the bus but not valid.
    in_valid = 1'b0; instr = 32'h12345678; ImmSel = 3'd3;
    repeat (2) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (imm_q !== last || imm_q_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL hold: got %h/%b want %h/0", imm_q, imm_q_valid, last);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    instr = 32'hFC012023; ImmSel = 3'd1; in_valid = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (imm_q !== 32'h0 || imm_q_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got %h/%b want 00000000/0", imm_q, imm_q_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (imm_q !== 32'h0 || imm_q_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_held: got %h/%b want 00000000/0", imm_q, imm_q_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (imm_q !== 32'hFFFFFFC0 || imm_q_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL first_capture: got %h/%b want ffffffc0/1", imm_q, imm_q_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; instr = 32'h0; ImmSel = 3'd0; in_valid = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/immediate_gen.md
# immediate_gen

Immediate generator for the single-cycle RV32I datapath. It extracts and sign-extends the immediate field of a 32-bit instruction according to the format select from the control unit. The combinational result drives the ALU B-mux and the branch/jump target adders in the same cycle. A registered copy with a valid flag is also provided for pipelined or debug consumers.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  system clock; registered outputs update on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all registered outputs.
- instr  input  32  instruction word.
- ImmSel  input  3  format select from control.
- in_valid  input  1  qualifies instr/ImmSel for the registered path.
- imm_out  output  32  combinational immediate.
- imm_illegal  output  1  combinational; 1 when ImmSel is 3'b111.
- imm_q  output  32  registered imm_out.
- imm_q_valid  output  1  registered in_valid.

## Operation
- ImmSel decode, with bit indices referring to instr:
  - 000 I-type: sign-extend [31:20].
  - 001 S-type: sign-extend {[31:25],[11:7]}.
  - 010 B-type: sign-extend {[31],[7],[30:25],[11:8],1'b0}, giving a 13-bit value.
  - 011 U-type: {[31:12],12'b0}, with no extension.
  - 100 J-type: sign-extend {[31],[19:12],[20],[30:21],1'b0}, giving a 21-bit value.
  - 101 shamt: zero-extend [24:20].
  - 110 CSR zimm: zero-extend [19:15].
  - 111: imm_out = 0 and imm_illegal = 1.
- Sign bit is always instr[31] for I/S/B/J.
- imm_out and imm_illegal depend only on instr and ImmSel, never on clk/rst.
- No X propagation: every ImmSel value, including 111, produces a defined output.

## Timing
- imm_out and imm_illegal have zero latency and are purely combinational.
- On the rising edge of clk:
  - When in_valid = 1: imm_q ← imm_out and imm_q_valid ← 1.
  - When in_valid = 0: imm_q holds its value and imm_q_valid ← 0.
- Registered-path latency is 1 cycle. Back-to-back valid inputs give one result per cycle, with no stall or backpressure.
- Reset:
  - While rst = 1: imm_q = 0 and imm_q_valid = 0 immediately, regardless of clk.
  - Reset asserted mid-stream discards the in-flight value.
  - The first capture occurs on the first rising edge after rst deasserts.
- The combinational outputs are unaffected by rst.

## Test plan
- I-type: instr=0xFFB10093 (ADDI x1,x2,-5), ImmSel=000 -> imm_out=0xFFFFFFFB.
- S-type: instr=0xFC012023 (SW -64), ImmSel=001 -> imm_out=0xFFFFFFC0.
- B-type and U-type:
  - instr=0x00410063, ImmSel=010 -> imm_out=0x00000000.
  - instr=0xABCD00B7, ImmSel=011 -> imm_out=0xABCD0000.
- J-type: instr=0xFFC0006F, ImmSel=100 -> imm_out=0xFFF007FC. Also instr=0xFC9FF0EF -> 0xFFFFFFC8 (-56).
- Extensions and default:
  - instr=0x01F01013 with ImmSel=101 -> imm_out=0x0000001F.
  - instr=0x000FD073 with ImmSel=110 -> imm_out=0x0000001F.
  - instr=0, ImmSel=111 -> imm_out=0, imm_illegal=1.
- Registered path:
  - Drive 3 back-to-back valid inputs; imm_q follows each one edge later with imm_q_valid=1.
  - Drop in_valid; imm_q holds and imm_q_valid=0.
  - Assert rst between edges; imm_q and imm_q_valid clear immediately.
